// File: rtl/vga_plot_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : Shared screen geometry, pixel record and arbiter state
//               encoding for the VGA pixel-write path.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int C_W      = 3;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        logic [C_W-1:0] colour;
    } pixel_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/vga_plot_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker. Returns the one-hot index
//               of the first set request bit, scanning upward from
//               i_last+1 and wrapping at N-1 back to 0.
// Ports       : i_req    - request vector
//               i_last   - index of the most recent owner
//               o_winner - one-hot winner, all zero when no request
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int N  = 2,
    parameter int LW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [LW-1:0] i_last,
    output logic [N-1:0]  o_winner
);
    import vga_pkg::*;

    // Scan from the farthest offset down to the nearest so the nearest
    // requester after i_last overwrites any earlier candidate.
    always_comb begin
        o_winner = '0;
        for (int k = N; k >= 1; k--) begin
            for (int i = 0; i < N; i++) begin
                if ((i == ((int'(i_last) + k) % N)) && i_req[i]) begin
                    o_winner    = '0;
                    o_winner[i] = 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/vga_plot_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vga_plot_arbiter
// Description : Shares the VGA adapter pixel-write port between NUM_REQ
//               drawing engines. Per-pixel req/gnt handshake, round-robin
//               ownership with bounded bursts, off-screen clipping and
//               registered adapter outputs (one cycle latency).
// Ports       : clk, rst             - clock, synchronous active-high reset
//               req/req_x/req_y/
//               req_colour           - packed per-requester pixel inputs
//               gnt                  - one-hot pixel accept (combinational)
//               vga_x/vga_y/
//               vga_colour/vga_plot  - registered adapter write port
//               busy                 - high while a requester owns the port
// Revision    : 1.0 - initial release
// ============================================================================
module vga_plot_arbiter
    import vga_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int MAX_BURST = 160,
    parameter int SCREEN_W  = vga_pkg::SCREEN_W,
    parameter int SCREEN_H  = vga_pkg::SCREEN_H
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ*X_W-1:0] req_x,
    input  logic [NUM_REQ*Y_W-1:0] req_y,
    input  logic [NUM_REQ*C_W-1:0] req_colour,
    output logic [NUM_REQ-1:0]     gnt,
    output logic [X_W-1:0]         vga_x,
    output logic [Y_W-1:0]         vga_y,
    output logic [C_W-1:0]         vga_colour,
    output logic                   vga_plot,
    output logic                   busy
);

    localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int BW = $clog2(MAX_BURST + 1);

    localparam logic [BW-1:0] c_max_burst = BW'(MAX_BURST);
    localparam logic [X_W:0]  c_x_lim     = (X_W+1)'(SCREEN_W);
    localparam logic [Y_W:0]  c_y_lim     = (Y_W+1)'(SCREEN_H);

    arb_state_t          r_state;
    logic [OW-1:0]       r_owner;
    logic [OW-1:0]       r_last;
    logic [BW-1:0]       r_burst_cnt;

    logic [NUM_REQ-1:0]  w_winner;
    logic [OW-1:0]       w_win_idx;
    logic [NUM_REQ-1:0]  w_own_hot;
    logic                w_req_own;
    pixel_t              w_pix;
    logic                w_accept;
    logic                w_others;
    logic                w_on_screen;
    logic [BW-1:0]       w_cnt_next;
    logic                w_cnt_hit;

    rr_pick #(
        .N  (NUM_REQ),
        .LW (OW)
    ) u_rr_pick (
        .i_req    (req),
        .i_last   (r_last),
        .o_winner (w_winner)
    );

    // One-hot winner to index for the owner register.
    always_comb begin
        w_win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_winner[i]) begin
                w_win_idx = OW'(i);
            end
        end
    end

    // Select the current owner's request bit and pixel slice.
    always_comb begin
        w_own_hot = '0;
        w_req_own = 1'b0;
        w_pix     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_owner == OW'(i)) begin
                w_own_hot[i] = 1'b1;
                w_req_own    = req[i];
                w_pix.x      = req_x[X_W*i +: X_W];
                w_pix.y      = req_y[Y_W*i +: Y_W];
                w_pix.colour = req_colour[C_W*i +: C_W];
            end
        end
    end

    assign w_accept    = (r_state == OWN) && w_req_own;
    assign w_others    = |(req & ~w_own_hot);
    assign w_on_screen = ({1'b0, w_pix.x} < c_x_lim) && ({1'b0, w_pix.y} < c_y_lim);
    assign w_cnt_next  = r_burst_cnt + BW'(1);
    assign w_cnt_hit   = (w_cnt_next == c_max_burst);

    assign gnt  = w_accept ? w_own_hot : '0;
    assign busy = (r_state == OWN);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_owner     <= '0;
            r_last      <= OW'(NUM_REQ - 1);
            r_burst_cnt <= '0;
            vga_x       <= '0;
            vga_y       <= '0;
            vga_colour  <= '0;
            vga_plot    <= 1'b0;
        end else begin
            // Clipped pixels are still consumed; they just never strobe.
            vga_plot <= w_accept && w_on_screen;
            if (w_accept && w_on_screen) begin
                vga_x      <= w_pix.x;
                vga_y      <= w_pix.y;
                vga_colour <= w_pix.colour;
            end

            case (r_state)
                IDLE: begin
                    if (|req) begin
                        r_owner     <= w_win_idx;
                        r_burst_cnt <= '0;
                        r_state     <= OWN;
                    end
                end
                OWN: begin
                    if (!w_req_own) begin
                        r_state <= IDLE;
                        r_last  <= r_owner;
                    end else if (w_cnt_hit) begin
                        // Burst limit: yield only if someone else is waiting,
                        // otherwise restart the count with no bubble.
                        r_burst_cnt <= '0;
                        if (w_others) begin
                            r_state <= IDLE;
                            r_last  <= r_owner;
                        end
                    end else begin
                        r_burst_cnt <= w_cnt_next;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_plot_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_plot_arbiter
// Description : Self-checking bench for vga_plot_arbiter (NUM_REQ=2,
//               MAX_BURST=4): vector table plus burst, streaming, reset and
//               full-screen fill sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_plot_arbiter;

    localparam int NR = 2;
    localparam int MB = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NR-1:0] req = '0;
    logic [NR*8-1:0] req_x = '0;
    logic [NR*7-1:0] req_y = '0;
    logic [NR*3-1:0] req_colour = '0;
    logic [NR-1:0] gnt;
    logic [7:0]    vga_x;
    logic [6:0]    vga_y;
    logic [2:0]    vga_colour;
    logic          vga_plot;
    logic          busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vga_plot_arbiter #(
        .NUM_REQ   (NR),
        .MAX_BURST (MB),
        .SCREEN_W  (160),
        .SCREEN_H  (120)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_colour (req_colour),
        .gnt        (gnt),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .busy       (busy)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0] req;
        int x0, y0, c0;
        int e_gnt, e_plot, e_x, e_y, e_c, e_busy;
    } vec_t;

    vec_t vecs[10];
    bit   seen[160][120];

    initial begin
        int plots, idx, pulses, dup, oob, tail, uncovered, exp_g;

        // Single pixel, then on-screen / clipped boundary pixels on r0.
        vecs[0] = '{2'b01,   5,   7, 3,  0, 0,   0,   0, 0, 0};
        vecs[1] = '{2'b01,   5,   7, 3,  1, 0,   0,   0, 0, 1};
        vecs[2] = '{2'b00,   5,   7, 3,  0, 1,   5,   7, 3, 1};
        vecs[3] = '{2'b00,   5,   7, 3,  0, 0,   5,   7, 3, 0};
        vecs[4] = '{2'b01, 159, 119, 1,  0, 0,   5,   7, 3, 0};
        vecs[5] = '{2'b01, 159, 119, 1,  1, 0,   5,   7, 3, 1};
        vecs[6] = '{2'b01, 160,   0, 2,  1, 1, 159, 119, 1, 1};
        vecs[7] = '{2'b01,   0, 120, 4,  1, 0, 159, 119, 1, 1};
        vecs[8] = '{2'b00,   0, 120, 4,  0, 0, 159, 119, 1, 1};
        vecs[9] = '{2'b00,   0,   0, 0,  0, 0, 159, 119, 1, 0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 10; v++) begin
            @(negedge clk);
            req        = vecs[v].req;
            req_x      = {8'd0, 8'(vecs[v].x0)};
            req_y      = {7'd0, 7'(vecs[v].y0)};
            req_colour = {3'd0, 3'(vecs[v].c0)};
            #1;
            chk($sformatf("vec%0d_gnt", v),    int'(gnt),        vecs[v].e_gnt);
            chk($sformatf("vec%0d_plot", v),   int'(vga_plot),   vecs[v].e_plot);
            chk($sformatf("vec%0d_x", v),      int'(vga_x),      vecs[v].e_x);
            chk($sformatf("vec%0d_y", v),      int'(vga_y),      vecs[v].e_y);
            chk($sformatf("vec%0d_colour", v), int'(vga_colour), vecs[v].e_c);
            chk($sformatf("vec%0d_busy", v),   int'(busy),       vecs[v].e_busy);
        end

        // Both stream; last=0 so r1 wins first. 4 pixels, bubble, 4 pixels...
        plots = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            req        = 2'b11;
            req_x      = {8'd20, 8'd10};
            req_y      = {7'd2, 7'd1};
            req_colour = {3'd6, 3'd5};
            #1;
            if ((c % 10) == 0 || (c % 10) == 5) exp_g = 0;
            else if ((c % 10) < 5)              exp_g = 2;
            else                                exp_g = 1;
            chk($sformatf("alt_gnt_c%0d", c), int'(gnt), exp_g);
            if (c >= 1 && c <= 10 && vga_plot) plots++;
            if (c == 2) chk("alt_x_r1", int'(vga_x), 20);
            if (c == 7) chk("alt_x_r0", int'(vga_x), 10);
        end
        chk("alt_plots_per_10", plots, 8);
        @(negedge clk); req = '0;
        repeat (3) @(negedge clk);

        // Reset during the 3rd pixel of an r0 burst (last is 0 here).
        @(negedge clk); req = 2'b01; req_x = {8'd0, 8'd30}; req_y = '0; #1;
        chk("rst_pre_idle_gnt", int'(gnt), 0);
        @(negedge clk); #1; chk("rst_pix1_gnt", int'(gnt), 1);
        @(negedge clk); #1; chk("rst_pix2_gnt", int'(gnt), 1);
        @(negedge clk); rst = 1'b1; #1; chk("rst_pix3_gnt", int'(gnt), 1);
        @(negedge clk); rst = 1'b0; req = 2'b11; #1;
        chk("rst_after_gnt",  int'(gnt),      0);
        chk("rst_after_plot", int'(vga_plot), 0);
        chk("rst_after_busy", int'(busy),     0);
        chk("rst_after_x",    int'(vga_x),    0);
        @(negedge clk); #1; chk("rst_first_winner_r0", int'(gnt), 1);
        @(negedge clk); req = '0;
        repeat (2) @(negedge clk);

        // r1 alone streams 10 pixels: no bubble when the burst count wraps.
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k <= 10) begin
                req   = 2'b10;
                req_x = {8'(k > 0 ? k - 1 : 0), 8'd0};
                req_y = {7'd3, 7'd0};
            end else begin
                req = '0;
            end
            #1;
            if (k == 0) chk("solo_idle_gnt", int'(gnt), 0);
            else if (k <= 10) chk($sformatf("solo_gnt_k%0d", k), int'(gnt), 2);
            if (k >= 2) begin
                chk($sformatf("solo_plot_k%0d", k), int'(vga_plot), 1);
                chk($sformatf("solo_x_k%0d", k),    int'(vga_x),    k - 2);
            end
        end
        repeat (2) @(negedge clk);

        // Full-screen fill on r0.
        idx = 0; pulses = 0; dup = 0; oob = 0; tail = 0;
        for (int cyc = 0; cyc < 20000; cyc++) begin
            @(negedge clk);
            if (vga_plot) begin
                pulses++;
                if (vga_x >= 8'd160 || vga_y >= 7'd120) oob++;
                else begin
                    if (seen[vga_x][vga_y]) dup++;
                    seen[vga_x][vga_y] = 1'b1;
                end
            end
            if (idx < 19200) begin
                req        = 2'b01;
                req_x      = {8'd0, 8'(idx % 160)};
                req_y      = {7'd0, 7'(idx / 160)};
                req_colour = {3'd0, 3'(idx % 8)};
            end else begin
                req = '0;
                tail++;
                if (tail > 3) break;
            end
            #1;
            if (gnt[0]) idx++;
        end
        uncovered = 0;
        for (int x = 0; x < 160; x++)
            for (int y = 0; y < 120; y++)
                if (!seen[x][y]) uncovered++;
        chk("fill_accepted",  idx,       19200);
        chk("fill_pulses",    pulses,    19200);
        chk("fill_dup",       dup,       0);
        chk("fill_oob",       oob,       0);
        chk("fill_uncovered", uncovered, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
